mdu: RTL and testbench

Multiply/divide unit for the five-stage pipeline. It sits in the E stage beside the ALU and takes the forwarded rs/rt operands. It runs multi-cycle multiply and divide operations into private HI/LO registers and raises `busy` so the D-stage hazard logic can stall any HI/LO-touching instruction. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_calc.sv | 51 +++++
 rtl/mdu.sv | 104 ++++++++++
 tb/tb_mdu.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op encodings, default latencies and decode predicates for the multiply/divide unit.
// Defining MDU_MADD_EN makes MADD/MADDU/MSUB/MSUBU multiply-class ops; otherwise they decode as NONE.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU});
`else
    return (op inside {OP_MULT, OP_MULTU});
`endif
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op inside {OP_DIV, OP_DIVU});
  endfunction

  function automatic logic is_hilo_read(input logic [3:0] op);
    return (op inside {OP_MFHI, OP_MFLO});
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result generator: 64-bit {HI,LO} candidate for every multiply/divide/accumulate op.
// Whether an op is actually accepted (MDU_MADD_EN gating) is decided by the top via is_mul().
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [63:0] res_o,
  output logic        we_o
);

  logic [63:0] a_sx, b_sx, prod_s, prod_u, acc;
  logic [31:0] a_mag, b_mag, den_mag, den_u, q_mag, r_mag, q_s, r_s;

  always_comb begin
    a_sx   = {{32{a_i[31]}}, a_i};
    b_sx   = {{32{b_i[31]}}, b_i};
    // Low 64 bits of a sign-extended product equal the signed 32x32 product.
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a_i} * {32'd0, b_i};
    acc    = {hi_i, lo_i};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow traps.
    a_mag   = a_i[31] ? (~a_i + 32'd1) : a_i;
    b_mag   = b_i[31] ? (~b_i + 32'd1) : b_i;
    den_mag = (b_mag == 32'd0) ? 32'd1 : b_mag;
    den_u   = (b_i == 32'd0) ? 32'd1 : b_i;
    q_mag   = a_mag / den_mag;
    r_mag   = a_mag % den_mag;
    q_s     = (a_i[31] ^ b_i[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s     = a_i[31] ? (~r_mag + 32'd1) : r_mag;

    res_o = 64'd0;
    we_o  = 1'b0;
    case (op_i)
      OP_MULT:  begin res_o = prod_s;               we_o = 1'b1; end
      OP_MULTU: begin res_o = prod_u;               we_o = 1'b1; end
      OP_DIV:   begin res_o = {r_s, q_s};           we_o = (b_i != 32'd0); end
      OP_DIVU:  begin res_o = {a_i % den_u, a_i / den_u}; we_o = (b_i != 32'd0); end
      OP_MADD:  begin res_o = acc + prod_s;         we_o = 1'b1; end
      OP_MADDU: begin res_o = acc + prod_u;         we_o = 1'b1; end
      OP_MSUB:  begin res_o = acc - prod_s;         we_o = 1'b1; end
      OP_MSUBU: begin res_o = acc - prod_u;         we_o = 1'b1; end
      default:  begin res_o = 64'd0;                we_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with private HI/LO; result is computed at issue and committed after a fixed latency.
// MDU_MADD_EN (see mdu_pkg) enables the multiply-accumulate ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       pend_hi_q, pend_lo_q, hi_q, lo_q;
  logic              pend_we_q, busy_q;
  logic [63:0]       calc_res_d;
  logic              calc_we_d;

  mdu_calc u_calc (
    .op_i  (mdu_op),
    .a_i   (A),
    .b_i   (B),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .res_o (calc_res_d),
    .we_o  (calc_we_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_mul(mdu_op) || is_div(mdu_op)) begin
              state_q   <= S_RUN;
              busy_q    <= 1'b1;
              cnt_q     <= is_div(mdu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              pend_hi_q <= calc_res_d[63:32];
              pend_lo_q <= calc_res_d[31:0];
              pend_we_q <= calc_we_d;
            end else if (mdu_op == OP_MTHI) begin
              hi_q <= A;
            end else if (mdu_op == OP_MTLO) begin
              lo_q <= A;
            end
          end
        end
        S_RUN: begin
          // Any start seen here is dropped; the pipeline stalls on busy.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (pend_we_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out = 32'd0;
    if (is_hilo_read(mdu_op)) begin
      out = (mdu_op == OP_MFHI) ? hi_q : lo_q;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomised self-checking bench for mdu against a behavioural HI/LO model, plus directed literal checks.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO, out;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  bit chk_en = 1'b0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  always #5 clk = ~clk;

  // Behavioural model: result computed with plain integer arithmetic, committed after a latency.
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_pend = 0;
  bit          m_commit = 0;
  int          m_cnt = 0;

  always @(posedge clk) begin : model
    longint sa, sb;
    logic [63:0] ua, ub, acc;
    sa  = longint'($signed(A));
    sb  = longint'($signed(B));
    ua  = {32'd0, A};
    ub  = {32'd0, B};
    acc = {m_hi, m_lo};
    if (reset) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_commit = 0; m_cnt = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && m_commit) {m_hi, m_lo} = m_pend;
    end else if (start) begin
      case (mdu_op)
        4'd1: begin m_pend = 64'(sa * sb); m_commit = 1; m_cnt = 5; end
        4'd2: begin m_pend = ua * ub;      m_commit = 1; m_cnt = 5; end
        4'd3: begin
          m_commit = (B != 0); m_cnt = 10;
          if (B != 0) m_pend = {32'(sa % sb), 32'(sa / sb)};
        end
        4'd4: begin
          m_commit = (B != 0); m_cnt = 10;
          if (B != 0) m_pend = {32'(ua % ub), 32'(ua / ub)};
        end
        4'd7: m_hi = A;
        4'd8: m_lo = A;
`ifdef MDU_MADD_EN
        4'd9:  begin m_pend = acc + 64'(sa * sb); m_commit = 1; m_cnt = 5; end
        4'd10: begin m_pend = acc + ua * ub;      m_commit = 1; m_cnt = 5; end
        4'd11: begin m_pend = acc - 64'(sa * sb); m_commit = 1; m_cnt = 5; end
        4'd12: begin m_pend = acc - ua * ub;      m_commit = 1; m_cnt = 5; end
`endif
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare, sampled away from the rising edge.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
      chk("HI", HI, m_hi);
      chk("LO", LO, m_lo);
      chk("out", out, (mdu_op == 4'd5) ? m_hi : (mdu_op == 4'd6) ? m_lo : 32'd0);
      if (start && busy && !reset) begin
        viol++;
        $display("[TB] protocol: start issued while busy at %0t (op=%0d)", $time, mdu_op);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    $display("[TB] txn op=%0d A=%h B=%h", op, a, b);
    start = 1'b1; mdu_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    #2;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
      #2;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    count_busy(n);
    if (n >= 50) begin
      tests++; fails++;
      $display("[TB] FAIL wait_idle: busy still %0d after %0d cycles, required 0", busy, n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);

    // Signed multiply and its busy window.
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    count_busy(n);
    chk("mult_busy_len", n, 32'd5);
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    chk("div_busy_len", n, 32'd10);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);

    issue(4'd4, 32'hFFFF_FFFF, 32'h10);
    wait_idle();
    chk("divu_LO", LO, 32'h0FFF_FFFF);
    chk("divu_HI", HI, 32'h0000_000F);

    // Divide by zero leaves HI/LO alone.
    issue(4'd7, 32'h1234, 32'd0);
    issue(4'd8, 32'h5678, 32'd0);
    issue(4'd3, 32'd99, 32'd0);
    count_busy(n);
    chk("div0_busy_len", n, 32'd10);
    chk("div0_HI", HI, 32'h1234);
    chk("div0_LO", LO, 32'h5678);
    mdu_op = 4'd5;
    #2;
    chk("mfhi_out", out, 32'h1234);
    @(negedge clk);
    mdu_op = 4'd0;

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("ovf_LO", LO, 32'h8000_0000);
    chk("ovf_HI", HI, 32'd0);

`ifdef MDU_MADD_EN
    issue(4'd7, 32'd0, 32'd0);
    issue(4'd8, 32'd1, 32'd0);
    issue(4'd9, 32'd2, 32'd3);
    count_busy(n);
    chk("madd_busy_len", n, 32'd5);
    chk("madd_HI", HI, 32'd0);
    chk("madd_LO", LO, 32'd7);
`else
    issue(4'd9, 32'd2, 32'd3);
    count_busy(n);
    chk("madd_off_busy", n, 32'd0);
    chk("madd_off_HI", HI, 32'd0);
    chk("madd_off_LO", LO, 32'h8000_0000);
`endif

    // Reset in the 4th busy cycle of a DIVU abandons it.
    issue(4'd7, 32'hAAAA_5555, 32'd0);
    issue(4'd4, 32'd1000, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_HI", HI, 32'd0);
    chk("rst_mid_LO", LO, 32'd0);
    repeat (15) @(negedge clk);
    #2;
    chk("rst_late_HI", HI, 32'd0);
    chk("rst_late_LO", LO, 32'd0);
    @(negedge clk);

    // A start while busy must be dropped and flagged.
    issue(4'd1, 32'd7, 32'd9);
    @(negedge clk);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    chk("ignored_viol", viol, 32'd1);
    chk("ignored_HI", HI, 32'd0);
    chk("ignored_LO", LO, 32'd63);

    // Randomised traffic checked cycle by cycle against the model.
    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), ($urandom_range(0, 7) == 0) ? 32'd0 : pick());
      wait_idle();
      mdu_op = ($urandom_range(0, 1) == 1) ? 4'd5 : 4'd6;
      @(negedge clk);
      mdu_op = 4'd0;
    end

    chk("final_viol", viol, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
